prbs5_checker: RTL

PRBS5_CHECKER -- requirements
Module: prbs5_checker

---
 rtl/prbs5_if.sv | 29 ++
 rtl/prbs5_checker.sv | 138 +++++++++++++
 2 files changed

// File: rtl/prbs5_if.sv
// Serial PRBS5 receive-side bus: qualified bit stream in, lock/error status out.
interface prbs5_if;
  logic       bit_in;
  logic       bit_valid;
  logic       clear_errors;
  logic       locked;
  logic       error;
  logic [7:0] err_count;

  // Stream source and status consumer
  modport master (
    output bit_in,
    output bit_valid,
    output clear_errors,
    input  locked,
    input  error,
    input  err_count
  );

  // The checker itself
  modport slave (
    input  bit_in,
    input  bit_valid,
    input  clear_errors,
    output locked,
    output error,
    output err_count
  );
endinterface

// File: rtl/prbs5_checker.sv
// PRBS5 checker: acquires lock on the s[n+5] = s[n] ^ s[n+2] stream, then
// counts bit errors while locked and drops lock after repeated mismatches.
module prbs5_checker (
  input  logic   clk,
  input  logic   reset,
  prbs5_if.slave bus
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [2:0] FILL_LEN       = 3'd5;
  localparam logic [4:0] LOCK_THRESHOLD = 5'd16;
  localparam logic [2:0] LOSS_THRESHOLD = 3'd4;
  localparam logic [4:0] GOOD_WINDOW    = 5'd31;
  localparam logic [7:0] ERR_MAX        = 8'hFF;

  logic [1:0] state_q, state_d;
  logic [4:0] hist_q, hist_d;
  logic [2:0] fill_q, fill_d;
  logic [4:0] match_q, match_d;
  logic [2:0] bad_q, bad_d;
  logic [4:0] good_q, good_d;
  logic       locked_q, locked_d;
  logic       error_q, error_d;
  logic [7:0] errCount_q, errCount_d;

  logic       expectedBit;
  logic       bitMatch;
  logic [4:0] histShifted;

  // The prediction always uses the history as it was before this bit arrives;
  // while locked the received bit is shifted in as-is so the checker resyncs.
  assign expectedBit = hist_q[0] ^ hist_q[2];
  assign bitMatch    = (bus.bit_in == expectedBit);
  assign histShifted = {bus.bit_in, hist_q[4:1]};

  // Next-state logic for acquisition, lock maintenance and error counting
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    match_d    = match_q;
    bad_d      = bad_q;
    good_d     = good_q;
    errCount_d = errCount_q;
    error_d    = 1'b0;

    if (bus.bit_valid) begin
      hist_d = histShifted;
      case (state_q)
        SEARCH: begin
          if (fill_q != FILL_LEN) begin
            fill_d = fill_q + 3'd1;
          end
          if ((fill_d == FILL_LEN) && (histShifted != 5'd0)) begin
            state_d = VERIFY;
            match_d = 5'd0;
          end
        end
        VERIFY: begin
          if (bitMatch) begin
            match_d = match_q + 5'd1;
            if (match_d == LOCK_THRESHOLD) begin
              state_d = LOCKED;
              bad_d   = 3'd0;
              good_d  = 5'd0;
            end
          end else begin
            state_d = SEARCH;
            fill_d  = 3'd1;
          end
        end
        LOCKED: begin
          if (!bitMatch) begin
            error_d = 1'b1;
            if (errCount_q != ERR_MAX) begin
              errCount_d = errCount_q + 8'd1;
            end
            bad_d  = bad_q + 3'd1;
            good_d = 5'd0;
          end else begin
            good_d = good_q + 5'd1;
            if (good_d == GOOD_WINDOW) begin
              bad_d  = 3'd0;
              good_d = 5'd0;
            end
          end
          if ((bad_d == LOSS_THRESHOLD) || (histShifted == 5'd0)) begin
            state_d = SEARCH;
            fill_d  = 3'd0;
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = 3'd0;
        end
      endcase
    end

    if (bus.clear_errors) begin
      errCount_d = 8'd0;
    end
  end

  assign locked_d = (state_d == LOCKED);

  // State and registered outputs, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      hist_q     <= 5'd0;
      fill_q     <= 3'd0;
      match_q    <= 5'd0;
      bad_q      <= 3'd0;
      good_q     <= 5'd0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      errCount_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      bad_q      <= bad_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      errCount_q <= errCount_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.error     = error_q;
  assign bus.err_count = errCount_q;

endmodule
